// File: rtl/led_pkg.sv
// Shared constants, scan-state encoding and helper functions for the LED matrix scan driver.
package led_pkg;

  localparam logic [1:0] LED_OFF  = 2'b00;
  localparam logic [1:0] LED_SLOW = 2'b01;
  localparam logic [1:0] LED_FAST = 2'b10;
  localparam logic [1:0] LED_ON   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clogb2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

  function automatic logic led_lit(input logic [1:0] mode, input logic slow_phase,
                                   input logic fast_phase);
    case (mode)
      LED_OFF:  return 1'b0;
      LED_SLOW: return slow_phase;
      LED_FAST: return fast_phase;
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Free-running 50% duty blink source: phase toggles every HALF_CYCLES clocks.
module led_blink_timer
  import led_pkg::*;
#(
  parameter int HALF_CYCLES = 500
) (
  input  logic clk,
  input  logic rst,
  output logic phase
);

  localparam int CNT_W = clogb2(HALF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             phase_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign phase = phase_reg;

endmodule

// File: rtl/led_matrix_scan.sv
// ROWS x COLS LED matrix scanner: blanked row multiplexing, PWM brightness, per-LED blink modes
// with a mode snapshot taken once per frame so a frame never shows a half-updated pattern.
module led_matrix_scan
  import led_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int CLK_PERIOD_NS  = 10,
  parameter int SLOW_PERIOD_MS = 1000,
  parameter int FAST_PERIOD_MS = 100,
  parameter int BRIGHT_W       = 4,
  parameter int BLANK_CYCLES   = 4,
  parameter bit X_ACT_LOW      = 1'b0,
  parameter bit Y_ACT_LOW      = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [BRIGHT_W-1:0]      brightness,
  input  logic [2*ROWS*COLS-1:0]   led_mode,
  output logic [COLS-1:0]          scan_x,
  output logic [ROWS-1:0]          scan_y,
  output logic                     frame_start
);

  localparam int DRIVE_CYCLES = 1 << BRIGHT_W;
  localparam int CNT_MAX      = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int CNT_W        = clogb2(CNT_MAX);
  localparam int ROW_W        = clogb2(ROWS);
  localparam int SLOW_HALF    = int'((64'(SLOW_PERIOD_MS) * 64'd500000) / 64'(CLK_PERIOD_NS));
  localparam int FAST_HALF    = int'((64'(FAST_PERIOD_MS) * 64'd500000) / 64'(CLK_PERIOD_NS));

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COLS-1:0]  X_IDLE     = {COLS{X_ACT_LOW}};
  localparam logic [ROWS-1:0]  Y_IDLE     = {ROWS{Y_ACT_LOW}};

  scan_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [ROW_W-1:0]     row_reg, row_next;
  logic [BRIGHT_W-1:0]  bri_q_reg;
  logic [2*ROWS*COLS-1:0] snap_reg;
  logic [COLS-1:0]      scan_x_reg, scan_x_next;
  logic [ROWS-1:0]      scan_y_reg, scan_y_next;
  logic                 frame_start_reg, frame_start_next;

  logic                 slow_phase, fast_phase;
  logic                 blank_entry, frame_entry;
  logic [1:0]           snap_mode [ROWS][COLS];
  logic [COLS-1:0]      col_lit;
  logic [ROWS-1:0]      row_onehot;

  led_blink_timer #(.HALF_CYCLES(SLOW_HALF)) u_slow_timer (
    .clk   (clk),
    .rst   (rst),
    .phase (slow_phase)
  );

  led_blink_timer #(.HALF_CYCLES(FAST_HALF)) u_fast_timer (
    .clk   (clk),
    .rst   (rst),
    .phase (fast_phase)
  );

  // Blink phase is applied live; only the mode itself comes from the frame snapshot.
  generate
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        assign snap_mode[gr][gi] = snap_reg[2*(gr*COLS+gi) +: 2];
      end
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_lit
      assign col_lit[gi] = led_lit(snap_mode[row_reg][gi], slow_phase, fast_phase);
    end
  endgenerate

  assign row_onehot = ROWS'(1) << row_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      row_reg         <= '0;
      bri_q_reg       <= '0;
      snap_reg        <= '0;
      scan_x_reg      <= X_IDLE;
      scan_y_reg      <= Y_IDLE;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      row_reg         <= row_next;
      if (blank_entry) bri_q_reg <= brightness;
      if (frame_entry) snap_reg  <= led_mode;
      scan_x_reg      <= scan_x_next;
      scan_y_reg      <= scan_y_next;
      frame_start_reg <= frame_start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    row_next   = row_reg;
    if (!enable) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      row_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_BLANK;
          cnt_next   = '0;
          row_next   = '0;
        end
        ST_BLANK: begin
          if (cnt_reg == BLANK_LAST) begin
            state_next = ST_DRIVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_DRIVE: begin
          if (cnt_reg == DRIVE_LAST) begin
            state_next = ST_BLANK;
            cnt_next   = '0;
            row_next   = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          row_next   = '0;
        end
      endcase
    end
  end

  // Outputs are gated by enable so that dropping it blanks the pins on the very next cycle.
  always_comb begin
    blank_entry      = enable && (state_reg == ST_BLANK) && (cnt_reg == '0);
    frame_entry      = blank_entry && (row_reg == '0);
    frame_start_next = frame_entry;
    scan_x_next      = X_IDLE;
    scan_y_next      = Y_IDLE;
    if (enable && (state_reg == ST_DRIVE)) begin
      scan_y_next = row_onehot ^ Y_IDLE;
      if (cnt_reg < CNT_W'(bri_q_reg)) scan_x_next = col_lit ^ X_IDLE;
    end
  end

  assign scan_x      = scan_x_reg;
  assign scan_y      = scan_y_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed + random bench for led_matrix_scan: two polarity variants checked each cycle against
// a scan-position model derived from row/frame timing arithmetic.
module tb_led_matrix_scan;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int BW   = 3;
  localparam int BLANK = 2;
  localparam int ROW_PERIOD = BLANK + (1 << BW);
  localparam int FRAME_PERIOD = ROWS * ROW_PERIOD;
  localparam int SLOW_HALF = 500;
  localparam int FAST_HALF = 50;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            enable = 1'b0;
  logic [BW-1:0]   brightness = '0;
  logic [2*ROWS*COLS-1:0] led_mode = '0;
  logic [COLS-1:0] x_a, x_b;
  logic [ROWS-1:0] y_a, y_b;
  logic            fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  // model state
  int k = 0;
  int e = 0;
  logic [2*ROWS*COLS-1:0] snap_m = '0;
  int bri_m = 0;
  logic [COLS-1:0] ex = '0;
  logic [ROWS-1:0] ey = '0;
  logic efs = 1'b0;

  always #5 clk = ~clk;

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .CLK_PERIOD_NS(1000000), .SLOW_PERIOD_MS(1000),
    .FAST_PERIOD_MS(100), .BRIGHT_W(BW), .BLANK_CYCLES(BLANK), .X_ACT_LOW(1'b0), .Y_ACT_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness), .led_mode(led_mode),
    .scan_x(x_a), .scan_y(y_a), .frame_start(fs_a)
  );

  led_matrix_scan #(
    .ROWS(ROWS), .COLS(COLS), .CLK_PERIOD_NS(1000000), .SLOW_PERIOD_MS(1000),
    .FAST_PERIOD_MS(100), .BRIGHT_W(BW), .BLANK_CYCLES(BLANK), .X_ACT_LOW(1'b1), .Y_ACT_LOW(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness), .led_mode(led_mode),
    .scan_x(x_b), .scan_y(y_b), .frame_start(fs_b)
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%b want=%b cycle=%0d", tag, got, want, k);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge, then compare at negedge.
  task automatic tick();
    int s, rowp, row, d, slow, fast;
    logic [1:0] mode;
    logic lit;
    @(posedge clk);
    ex = '0; ey = '0; efs = 1'b0;
    if (!rst) begin
      k = 0; e = 0;
    end else begin
      k++;
      if (enable) begin
        if (e > 0) begin
          s    = e - 1;
          rowp = s % ROW_PERIOD;
          row  = (s / ROW_PERIOD) % ROWS;
          if (rowp == 0) begin
            bri_m = int'(brightness);
            if (row == 0) begin
              snap_m = led_mode;
              efs = 1'b1;
            end
          end
          if (rowp >= BLANK) begin
            d = rowp - BLANK;
            ey[row] = 1'b1;
            slow = ((k - 1) / SLOW_HALF) % 2;
            fast = ((k - 1) / FAST_HALF) % 2;
            for (int c = 0; c < COLS; c++) begin
              mode = snap_m[2*(row*COLS+c) +: 2];
              lit = (mode == 2'b11) || (mode == 2'b01 && slow == 1) || (mode == 2'b10 && fast == 1);
              ex[c] = lit && (d < bri_m);
            end
          end
        end
        e++;
      end else begin
        e = 0;
      end
    end
    @(negedge clk);
    chk("scan_x_a", x_a, ex);
    chk("scan_y_a", y_a, ~ey);
    chk("frame_start_a", {3'b000, fs_a}, {3'b000, efs});
    chk("scan_x_b", x_b, ~ex);
    chk("scan_y_b", y_b, ey);
    chk("frame_start_b", {3'b000, fs_b}, {3'b000, efs});
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_fs(input int budget);
    int n;
    n = 0;
    while (fs_a !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_start_wait", {3'b000, fs_a}, 4'b0001);
  endtask

  initial begin
    // reset state
    step(3);

    // release with enable high: frame_start two edges later
    rst = 1'b1;
    led_mode = '1;
    brightness = 3'd5;
    enable = 1'b1;
    tick();
    chk("fs_latency_1", {3'b000, fs_a}, 4'b0000);
    tick();
    chk("fs_latency_2", {3'b000, fs_a}, 4'b0001);

    // brightness 5, 0, 7
    step(FRAME_PERIOD);
    brightness = 3'd0;
    step(FRAME_PERIOD + 5);
    brightness = 3'd7;
    step(FRAME_PERIOD + 5);

    // blink: LED0 slow, LED1 fast
    led_mode = 32'h0000_0009;
    step(1200);

    // snapshot: change mid row 1 has no effect until next frame
    led_mode = '0;
    wait_fs(FRAME_PERIOD + 5);
    step(ROW_PERIOD + BLANK + 3);
    led_mode = '1;
    step(FRAME_PERIOD + 20);

    // enable drop during row 2 drive
    wait_fs(FRAME_PERIOD + 5);
    step(2 * ROW_PERIOD + BLANK + 2);
    enable = 1'b0;
    step(3);
    enable = 1'b1;
    step(FRAME_PERIOD + 10);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 15) == 0) led_mode = {$urandom};
      if ($urandom_range(0, 9) == 0) brightness = BW'($urandom_range(0, 7));
      if (enable && $urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
    end

    // asynchronous reset in the middle of a lit drive phase
    enable = 1'b1;
    brightness = 3'd7;
    led_mode = '1;
    wait_fs(2 * FRAME_PERIOD);
    step(BLANK + 3);
    chk("pre_reset_lit", x_a, 4'b1111);
    rst = 1'b0;
    #1;
    chk("async_rst_x_a", x_a, 4'b0000);
    chk("async_rst_y_a", y_a, 4'b1111);
    chk("async_rst_fs_a", {3'b000, fs_a}, 4'b0000);
    chk("async_rst_x_b", x_b, 4'b1111);
    chk("async_rst_y_b", y_b, 4'b0000);
    step(2);
    rst = 1'b1;
    tick();
    tick();
    chk("restart_fs", {3'b000, fs_a}, 4'b0001);
    step(FRAME_PERIOD + 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
